npu_dpram_scratchpad: RTL and testbench
=======================================

Name: npu_dpram_scratchpad

Overview:
- Parametrised true dual-port scratchpad for NPU weight and activation buffers.
- Next generation of the fixed 4096x16 Avalon dual-port SRAM: configurable width, depth and read latency.
- Adds a hardware clear-on-reset engine, a write-first mixed-port bypass, same-address write arbitration and Avalon readdatavalid signalling.
- Both ports run on one clock. Each port sits behind an Avalon-MM slave (s1 = port A, s2 = port B).

Parameters:
- DATA_W, 16, data width in bits; must be a multiple of 8.
- ADDR_W, 12, address width; depth = 2**ADDR_W words.
- READ_LATENCY, 1, read latency in cycles, from accepted read to readdatavalid; legal values 1 or 2.
- CLEAR_ON_RESET, 1, 1 = zero every word after reset; 0 = no clear, memory contents undefined.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- a_address  in  ADDR_W  port A word address
- a_byteenable  in  DATA_W/8  port A byte lanes
- a_chipselect  in  1  port A select
- a_write  in  1  port A write strobe
- a_read  in  1  port A read strobe
- a_writedata  in  DATA_W  port A write data
- a_readdata  out  DATA_W  port A read data
- a_readdatavalid  out  1  port A read data valid
- a_waitrequest  out  1  port A stall
- b_address, b_byteenable, b_chipselect, b_write, b_read, b_writedata, b_readdata, b_readdatavalid, b_waitrequest: identical to the port A signals, for port B
- clearing  out  1  clear engine active
- wr_collision  out  1  one-cycle pulse on a same-address, same-cycle write

Behaviour:
- Reset (synchronous, active-high), with reset values of all outputs:
  - readdata = 0, readdatavalid = 0, wr_collision = 0.
  - Read pipelines are flushed.
  - With CLEAR_ON_RESET=1: clearing = 1 and waitrequest = 1 on both ports.
  - With CLEAR_ON_RESET=0: clearing = 0 and waitrequest = 0.
- Clear FSM states IDLE and CLEAR:
  - reset -> CLEAR with clr_addr = 0.
  - Each CLEAR cycle writes 0 (all bytes) to clr_addr, then increments it.
  - At clr_addr = 2**ADDR_W-1 the FSM moves to IDLE on the next edge. Total: exactly 2**ADDR_W cycles after reset deasserts.
  - Reset asserted mid-clear restarts the clear at address 0.
- In IDLE: clearing = 0, waitrequest = 0 on both ports.
- Request acceptance:
  - A request is accepted when chipselect & (read | write) & ~waitrequest.
  - While waitrequest = 1, requests are not accepted; the master holds them per Avalon rules.
- Write:
  - Committed at the accepting edge.
  - Only bytes with byteenable = 1 are updated.
- Read:
  - readdatavalid pulses exactly READ_LATENCY cycles after acceptance, and readdata is valid only in that cycle.
  - readdata holds its last value otherwise.
  - Reads are fully pipelined: back-to-back reads give back-to-back valids.
- read and write asserted together on one port: treated as a write; no readdatavalid.
- Mixed-port read-during-write, same address, same cycle: write-first. The reader returns the newly written bytes for enabled lanes and the old bytes elsewhere. Implemented with a bypass, not relying on the RAM macro.
- Both ports write the same address in the same cycle:
  - Per byte, port A wins where both enables are set.
  - Port B bytes enabled only on B are written.
  - wr_collision pulses 1 cycle, aligned to the edge after acceptance.
- Address wrap: none. An address is always in range because depth = 2**ADDR_W.
- Storage is inferred RAM. The bypass, clear mux and arbitration are in fabric.

Optional Feature:
- Macro: NPU_DPRAM_STATS_EN.
- When defined, adds outputs a_rd_cnt, a_wr_cnt, b_rd_cnt, b_wr_cnt and coll_cnt, each 32-bit.
  - Each counter increments on the corresponding accepted request or collision.
  - Counters saturate at 0xFFFFFFFF and are cleared by reset.
  - Clear-engine writes are not counted.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Clear after reset (ADDR_W=4, CLEAR_ON_RESET=1): release reset -> clearing = 1 and waitrequest = 1 for exactly 16 cycles; then a read of every address returns 0x0000.
- Byte-enable write: A writes 0xBEEF to addr 5, then A writes 0x12xx with byteenable 2'b10 -> B reads addr 5 and gets 0x12EF, with readdatavalid exactly READ_LATENCY cycles after acceptance (check both latencies 1 and 2).
- Mixed-port write-first: same cycle, A writes 0xA5A5 to addr 7 while B reads addr 7 (old value 0x0000) -> B readdata = 0xA5A5.
- Same-address write collision: same cycle, A writes 0x1111 with be 2'b01 and B writes 0x2222 with be 2'b11 to addr 3 -> wr_collision pulses once; addr 3 then reads 0x2211.
- Reset during clear: assert reset at clr_addr = 9 after pre-writing nonzero data, deassert it -> clear restarts from 0, takes the full 16 cycles, and all words read 0.
- With NPU_DPRAM_STATS_EN defined: 3 A reads, 2 B writes, 1 collision -> a_rd_cnt = 3, b_wr_cnt = 2 (plus 1 from the collision write, total 3), coll_cnt = 1; reset clears all counters to 0.

Source files
------------

// File: rtl/npu_dpram_scratchpad.sv
// npu_dpram_scratchpad: parametrised true dual-port scratchpad, two Avalon-MM slaves
// on one clock. Hardware clear after reset, write-first mixed-port bypass, per-byte
// same-address write arbitration (port A wins), readdatavalid after READ_LATENCY.
// Optional macro NPU_DPRAM_STATS_EN adds saturating 32-bit request/collision counters.
module npu_dpram_scratchpad #(
    parameter int unsigned DATA_W         = 16,
    parameter int unsigned ADDR_W         = 12,
    parameter int unsigned READ_LATENCY   = 1,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     a_address,
    input  logic [DATA_W/8-1:0]   a_byteenable,
    input  logic                  a_chipselect,
    input  logic                  a_write,
    input  logic                  a_read,
    input  logic [DATA_W-1:0]     a_writedata,
    output logic [DATA_W-1:0]     a_readdata,
    output logic                  a_readdatavalid,
    output logic                  a_waitrequest,
    input  logic [ADDR_W-1:0]     b_address,
    input  logic [DATA_W/8-1:0]   b_byteenable,
    input  logic                  b_chipselect,
    input  logic                  b_write,
    input  logic                  b_read,
    input  logic [DATA_W-1:0]     b_writedata,
    output logic [DATA_W-1:0]     b_readdata,
    output logic                  b_readdatavalid,
    output logic                  b_waitrequest,
    output logic                  clearing,
    output logic                  wr_collision
`ifdef NPU_DPRAM_STATS_EN
    ,
    output logic [31:0]           a_rd_cnt,
    output logic [31:0]           a_wr_cnt,
    output logic [31:0]           b_rd_cnt,
    output logic [31:0]           b_wr_cnt,
    output logic [31:0]           coll_cnt
`endif
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic {ST_IDLE, ST_CLEAR} state_e;
    localparam state_e RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

    logic [DATA_W-1:0] mem [DEPTH];

    // Index 0 = port A, index 1 = port B
    logic [ADDR_W-1:0] p_addr  [2];
    logic [NB-1:0]     p_be    [2];
    logic [DATA_W-1:0] p_wdata [2];
    logic [1:0]        p_cs, p_rd, p_wr;

    assign p_addr[0]  = a_address;
    assign p_addr[1]  = b_address;
    assign p_be[0]    = a_byteenable;
    assign p_be[1]    = b_byteenable;
    assign p_wdata[0] = a_writedata;
    assign p_wdata[1] = b_writedata;
    assign p_cs       = {b_chipselect, a_chipselect};
    assign p_rd       = {b_read, a_read};
    assign p_wr       = {b_write, a_write};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              busy_q, busy_d;
    logic              wr_collision_q, wr_collision_d;
    logic [1:0]        vld1_q, vld1_d;
    logic [DATA_W-1:0] byp_mask_q [2], byp_mask_d [2];
    logic [DATA_W-1:0] byp_data_q [2], byp_data_d [2];
    logic [DATA_W-1:0] ram_rd_data [2];
    logic [DATA_W-1:0] rd1_c [2];
    logic [DATA_W-1:0] rdata_o [2];
    logic [1:0]        rdv_o;

    logic [1:0]        wr_c, rd_c;
    logic              same_addr_c, coll_c, clear_we_c;
    logic [NB-1:0]     be_eff_c [2];

    function automatic logic [DATA_W-1:0] lane_mask(input logic [NB-1:0] be);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < NB; i++) m[i*8 +: 8] = {8{be[i]}};
        return m;
    endfunction

    // Request decode, same-address arbitration (A wins shared lanes) and bypass capture
    always_comb begin
        wr_c        = '0;
        rd_c        = '0;
        same_addr_c = (p_addr[0] == p_addr[1]);
        for (int p = 0; p < 2; p++) begin
            wr_c[p] = p_cs[p] & p_wr[p] & ~busy_q & ~reset;
            rd_c[p] = p_cs[p] & p_rd[p] & ~p_wr[p] & ~busy_q & ~reset;
        end
        coll_c      = wr_c[0] & wr_c[1] & same_addr_c;
        be_eff_c[0] = p_be[0];
        be_eff_c[1] = coll_c ? (p_be[1] & ~p_be[0]) : p_be[1];
        for (int p = 0; p < 2; p++) begin
            byp_mask_d[p] = byp_mask_q[p];
            byp_data_d[p] = byp_data_q[p];
            if (rd_c[p]) begin
                byp_mask_d[p] = (wr_c[1-p] && same_addr_c) ? lane_mask(p_be[1-p]) : '0;
                byp_data_d[p] = p_wdata[1-p];
            end
            rd1_c[p] = (ram_rd_data[p] & ~byp_mask_q[p]) | (byp_data_q[p] & byp_mask_q[p]);
        end
        vld1_d         = rd_c;
        wr_collision_d = coll_c;
    end

    // Clear engine next state: one word per cycle, IDLE after the last address
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            ST_CLEAR: begin
                clr_addr_d = clr_addr_q + ADDR_W'(1);
                if (clr_addr_q == '1) state_d = ST_IDLE;
            end
            default: ;
        endcase
        busy_d     = (state_d == ST_CLEAR);
        clear_we_c = (state_q == ST_CLEAR) & ~reset;
    end

    // Control and stage-1 read registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= RST_STATE;
            clr_addr_q     <= '0;
            busy_q         <= (RST_STATE == ST_CLEAR);
            wr_collision_q <= 1'b0;
            vld1_q         <= '0;
            for (int p = 0; p < 2; p++) begin
                byp_mask_q[p] <= '0;
                byp_data_q[p] <= '0;
            end
        end else begin
            state_q        <= state_d;
            clr_addr_q     <= clr_addr_d;
            busy_q         <= busy_d;
            wr_collision_q <= wr_collision_d;
            vld1_q         <= vld1_d;
            for (int p = 0; p < 2; p++) begin
                byp_mask_q[p] <= byp_mask_d[p];
                byp_data_q[p] <= byp_data_d[p];
            end
        end
    end

    // RAM write ports: clear word, then B lanes, then A lanes
    always_ff @(posedge clk) begin
        if (clear_we_c) mem[clr_addr_q] <= '0;
        for (int i = 0; i < NB; i++) begin
            if (wr_c[1] && be_eff_c[1][i]) mem[p_addr[1]][i*8 +: 8] <= p_wdata[1][i*8 +: 8];
            if (wr_c[0] && be_eff_c[0][i]) mem[p_addr[0]][i*8 +: 8] <= p_wdata[0][i*8 +: 8];
        end
    end

    // RAM read ports with resettable output register; hold between reads
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (reset)        ram_rd_data[p] <= '0;
            else if (rd_c[p]) ram_rd_data[p] <= mem[p_addr[p]];
        end
    end

    // Optional second read stage
    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [DATA_W-1:0] rd2_data_q [2], rd2_data_d [2];
            logic [1:0]        rd2_vld_q, rd2_vld_d;

            // Capture the merged word only when stage 1 is valid
            always_comb begin
                rd2_vld_d = vld1_q;
                for (int p = 0; p < 2; p++)
                    rd2_data_d[p] = vld1_q[p] ? rd1_c[p] : rd2_data_q[p];
            end

            // Stage-2 registers
            always_ff @(posedge clk) begin
                if (reset) begin
                    rd2_vld_q <= '0;
                    for (int p = 0; p < 2; p++) rd2_data_q[p] <= '0;
                end else begin
                    rd2_vld_q <= rd2_vld_d;
                    for (int p = 0; p < 2; p++) rd2_data_q[p] <= rd2_data_d[p];
                end
            end

            assign rdata_o[0] = rd2_data_q[0];
            assign rdata_o[1] = rd2_data_q[1];
            assign rdv_o      = rd2_vld_q;
        end else begin : g_lat1
            assign rdata_o[0] = rd1_c[0];
            assign rdata_o[1] = rd1_c[1];
            assign rdv_o      = vld1_q;
        end
    endgenerate

    assign a_readdata      = rdata_o[0];
    assign b_readdata      = rdata_o[1];
    assign a_readdatavalid = rdv_o[0];
    assign b_readdatavalid = rdv_o[1];
    assign a_waitrequest   = busy_q;
    assign b_waitrequest   = busy_q;
    assign clearing        = busy_q;
    assign wr_collision    = wr_collision_q;

`ifdef NPU_DPRAM_STATS_EN
    logic [31:0] cnt_q [5], cnt_d [5];
    logic [4:0]  inc_c;

    // Saturating counters: a_rd, a_wr, b_rd, b_wr, collision
    always_comb begin
        inc_c = {coll_c, wr_c[1], rd_c[1], wr_c[0], rd_c[0]};
        for (int i = 0; i < 5; i++)
            cnt_d[i] = (inc_c[i] && (cnt_q[i] != '1)) ? cnt_q[i] + 32'd1 : cnt_q[i];
    end

    // Counter registers
    always_ff @(posedge clk) begin
        for (int i = 0; i < 5; i++) begin
            if (reset) cnt_q[i] <= '0;
            else       cnt_q[i] <= cnt_d[i];
        end
    end

    assign a_rd_cnt = cnt_q[0];
    assign a_wr_cnt = cnt_q[1];
    assign b_rd_cnt = cnt_q[2];
    assign b_wr_cnt = cnt_q[3];
    assign coll_cnt = cnt_q[4];
`endif

endmodule

// File: tb/tb_npu_dpram_scratchpad.sv
// Bench for npu_dpram_scratchpad: two instances (READ_LATENCY 1 and 2, ADDR_W=4) share
// stimulus; a word-array reference model predicts reads, collisions and counters.
module tb_npu_dpram_scratchpad;

    localparam int DEPTH = 16;
    localparam int MAXC  = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [3:0]  a_address, b_address;
    logic [1:0]  a_be, b_be;
    logic        a_cs, a_wr, a_rd, b_cs, b_wr, b_rd;
    logic [15:0] a_wd, b_wd;

    logic [15:0] o_rdata [2][2];
    logic        o_rdv   [2][2];
    logic        o_wait  [2][2];
    logic        o_clr   [2];
    logic        o_coll  [2];
`ifdef NPU_DPRAM_STATS_EN
    logic [31:0] o_cnt   [2][5];
`endif

    npu_dpram_scratchpad #(.DATA_W(16), .ADDR_W(4), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) u_lat1 (
        .clk(clk), .reset(reset),
        .a_address(a_address), .a_byteenable(a_be), .a_chipselect(a_cs), .a_write(a_wr),
        .a_read(a_rd), .a_writedata(a_wd), .a_readdata(o_rdata[0][0]),
        .a_readdatavalid(o_rdv[0][0]), .a_waitrequest(o_wait[0][0]),
        .b_address(b_address), .b_byteenable(b_be), .b_chipselect(b_cs), .b_write(b_wr),
        .b_read(b_rd), .b_writedata(b_wd), .b_readdata(o_rdata[0][1]),
        .b_readdatavalid(o_rdv[0][1]), .b_waitrequest(o_wait[0][1]),
        .clearing(o_clr[0]), .wr_collision(o_coll[0])
`ifdef NPU_DPRAM_STATS_EN
        , .a_rd_cnt(o_cnt[0][0]), .a_wr_cnt(o_cnt[0][1]), .b_rd_cnt(o_cnt[0][2]),
        .b_wr_cnt(o_cnt[0][3]), .coll_cnt(o_cnt[0][4])
`endif
    );

    npu_dpram_scratchpad #(.DATA_W(16), .ADDR_W(4), .READ_LATENCY(2), .CLEAR_ON_RESET(1)) u_lat2 (
        .clk(clk), .reset(reset),
        .a_address(a_address), .a_byteenable(a_be), .a_chipselect(a_cs), .a_write(a_wr),
        .a_read(a_rd), .a_writedata(a_wd), .a_readdata(o_rdata[1][0]),
        .a_readdatavalid(o_rdv[1][0]), .a_waitrequest(o_wait[1][0]),
        .b_address(b_address), .b_byteenable(b_be), .b_chipselect(b_cs), .b_write(b_wr),
        .b_read(b_rd), .b_writedata(b_wd), .b_readdata(o_rdata[1][1]),
        .b_readdatavalid(o_rdv[1][1]), .b_waitrequest(o_wait[1][1]),
        .clearing(o_clr[1]), .wr_collision(o_coll[1])
`ifdef NPU_DPRAM_STATS_EN
        , .a_rd_cnt(o_cnt[1][0]), .a_wr_cnt(o_cnt[1][1]), .b_rd_cnt(o_cnt[1][2]),
        .b_wr_cnt(o_cnt[1][3]), .coll_cnt(o_cnt[1][4])
`endif
    );

    // Reference model state
    logic [15:0] ref_mem [DEPTH];
    int          clr_ptr;
    int          cyc;
    bit          acc_rd   [2][MAXC];
    logic [15:0] acc_data [2][MAXC];
    bit          rst_edge [MAXC];
    logic        exp_rdv   [2][2];
    logic [15:0] exp_rdata [2][2];
    logic        exp_coll;
    int          m_cnt [5];
    int          n_tests, n_fail;

    task automatic idle();
        a_cs = 0; a_wr = 0; a_rd = 0; b_cs = 0; b_wr = 0; b_rd = 0;
    endtask

    // Advance one clock edge and update the model with what that edge does
    task automatic step();
        logic ra, wa, rb, wb, busy, same;
        logic [15:0] rv;
        int c;
        @(posedge clk);
        c = cyc;
        if (c >= MAXC - 1) begin
            $display("FAIL cycle_budget: got %0d cycles, limit %0d", c, MAXC - 1);
            $fatal(1, "cycle budget exhausted");
        end
        busy = (clr_ptr < DEPTH);
        same = (a_address == b_address);
        wa = !reset && !busy && a_cs && a_wr;
        ra = !reset && !busy && a_cs && a_rd && !a_wr;
        wb = !reset && !busy && b_cs && b_wr;
        rb = !reset && !busy && b_cs && b_rd && !b_wr;
        if (reset) begin
            clr_ptr = 0;
            rst_edge[c] = 1;
            for (int i = 0; i < 5; i++) m_cnt[i] = 0;
        end else if (busy) begin
            ref_mem[clr_ptr] = 16'h0000;
            clr_ptr++;
        end
        if (ra) begin
            rv = ref_mem[a_address];
            if (wb && same) for (int i = 0; i < 2; i++) if (b_be[i]) rv[i*8 +: 8] = b_wd[i*8 +: 8];
            acc_rd[0][c] = 1; acc_data[0][c] = rv;
        end
        if (rb) begin
            rv = ref_mem[b_address];
            if (wa && same) for (int i = 0; i < 2; i++) if (a_be[i]) rv[i*8 +: 8] = a_wd[i*8 +: 8];
            acc_rd[1][c] = 1; acc_data[1][c] = rv;
        end
        // B first, then A: A's lanes win on a shared address
        if (wb) for (int i = 0; i < 2; i++) if (b_be[i]) ref_mem[b_address][i*8 +: 8] = b_wd[i*8 +: 8];
        if (wa) for (int i = 0; i < 2; i++) if (a_be[i]) ref_mem[a_address][i*8 +: 8] = a_wd[i*8 +: 8];
        exp_coll = wa && wb && same;
        m_cnt[0] += int'(ra); m_cnt[1] += int'(wa); m_cnt[2] += int'(rb); m_cnt[3] += int'(wb);
        m_cnt[4] += int'(exp_coll);
        for (int l = 0; l < 2; l++) begin
            for (int p = 0; p < 2; p++) begin
                int k;
                bit v;
                k = c - l;
                v = (k >= 0) && acc_rd[p][k] && !rst_edge[c];
                if (rst_edge[c]) exp_rdata[l][p] = 16'h0000;
                if (v) exp_rdata[l][p] = acc_data[p][k];
                exp_rdv[l][p] = v;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        reset = 1; idle();
        a_address = 0; b_address = 0; a_be = 0; b_be = 0; a_wd = 0; b_wd = 0;
        step(); step();
        for (int l = 0; l < 2; l++) begin
            for (int p = 0; p < 2; p++) begin
                n_tests++;
                if (o_rdata[l][p] !== 16'h0000 || o_rdv[l][p] !== 1'b0 || o_wait[l][p] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL reset_port lat%0d p%0d: got d=%h v=%b w=%b, want d=0000 v=0 w=1",
                             l + 1, p, o_rdata[l][p], o_rdv[l][p], o_wait[l][p]);
                end
            end
            n_tests++;
            if (o_clr[l] !== 1'b1 || o_coll[l] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_ctl lat%0d: got clearing=%b coll=%b, want 1 0", l + 1, o_clr[l], o_coll[l]);
            end
        end
    endtask

    // Release reset, count clear cycles (a read is held during the clear), then read every word
    task automatic test_clear(input string tag);
        int cnt;
        reset = 0; idle();
        a_cs = 1; a_rd = 1; a_address = 4'd0;
        cnt = 0;
        while (o_clr[0] === 1'b1 && cnt < 40) begin
            for (int l = 0; l < 2; l++) begin
                n_tests++;
                if (o_clr[l] !== 1'b1 || o_wait[l][0] !== 1'b1 || o_wait[l][1] !== 1'b1 ||
                    o_rdv[l][0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s_busy lat%0d: got clr=%b wa=%b wb=%b va=%b, want 1 1 1 0",
                             tag, l + 1, o_clr[l], o_wait[l][0], o_wait[l][1], o_rdv[l][0]);
                end
            end
            cnt++;
            step();
        end
        n_tests++;
        if (cnt != 16) begin
            n_fail++;
            $display("FAIL %s_len: got %0d clearing cycles, want 16", tag, cnt);
        end
        for (int i = 0; i < 18; i++) begin
            if (i < 16) begin
                a_cs = 1; a_rd = 1; a_address = 4'(i);
                b_cs = 1; b_rd = 1; b_address = 4'(15 - i);
            end else idle();
            step();
            for (int l = 0; l < 2; l++) begin
                for (int p = 0; p < 2; p++) begin
                    n_tests++;
                    if (o_rdv[l][p] !== exp_rdv[l][p] || o_rdata[l][p] !== exp_rdata[l][p] ||
                        (o_rdv[l][p] === 1'b1 && o_rdata[l][p] !== 16'h0000)) begin
                        n_fail++;
                        $display("FAIL %s_read lat%0d p%0d: got v=%b d=%h, want v=%b d=%h (zero)",
                                 tag, l + 1, p, o_rdv[l][p], o_rdata[l][p], exp_rdv[l][p], exp_rdata[l][p]);
                    end
                end
            end
        end
    endtask

    task automatic test_byte_enable();
        idle();
        a_cs = 1; a_wr = 1; a_address = 4'd5; a_be = 2'b11; a_wd = 16'hBEEF; step();
        a_be = 2'b10; a_wd = 16'h12AB; step();
        idle(); b_cs = 1; b_rd = 1; b_address = 4'd5; step();
        idle();
        n_tests++;
        if (o_rdv[0][1] !== 1'b1 || o_rdata[0][1] !== 16'h12EF || o_rdv[1][1] !== 1'b0) begin
            n_fail++;
            $display("FAIL be_lat1_t1: got v1=%b d1=%h v2=%b, want 1 12ef 0", o_rdv[0][1], o_rdata[0][1], o_rdv[1][1]);
        end
        step();
        n_tests++;
        if (o_rdv[0][1] !== 1'b0 || o_rdata[0][1] !== 16'h12EF || o_rdv[1][1] !== 1'b1 || o_rdata[1][1] !== 16'h12EF) begin
            n_fail++;
            $display("FAIL be_t2: got v1=%b d1=%h v2=%b d2=%h, want 0 12ef 1 12ef",
                     o_rdv[0][1], o_rdata[0][1], o_rdv[1][1], o_rdata[1][1]);
        end
        step();
        n_tests++;
        if (o_rdv[1][1] !== 1'b0 || o_rdata[1][1] !== 16'h12EF) begin
            n_fail++;
            $display("FAIL be_lat2_hold: got v=%b d=%h, want 0 12ef", o_rdv[1][1], o_rdata[1][1]);
        end
    endtask

    task automatic test_write_first();
        idle();
        a_cs = 1; a_wr = 1; a_address = 4'd7; a_be = 2'b11; a_wd = 16'hA5A5;
        b_cs = 1; b_rd = 1; b_address = 4'd7;
        step(); idle();
        n_tests++;
        if (o_rdv[0][1] !== 1'b1 || o_rdata[0][1] !== 16'hA5A5) begin
            n_fail++;
            $display("FAIL wf_b_lat1: got v=%b d=%h, want 1 a5a5", o_rdv[0][1], o_rdata[0][1]);
        end
        step();
        n_tests++;
        if (o_rdv[1][1] !== 1'b1 || o_rdata[1][1] !== 16'hA5A5) begin
            n_fail++;
            $display("FAIL wf_b_lat2: got v=%b d=%h, want 1 a5a5", o_rdv[1][1], o_rdata[1][1]);
        end
        a_cs = 1; a_rd = 1; a_address = 4'd7;
        b_cs = 1; b_wr = 1; b_address = 4'd7; b_be = 2'b01; b_wd = 16'h3C3C;
        step(); idle();
        n_tests++;
        if (o_rdv[0][0] !== 1'b1 || o_rdata[0][0] !== 16'hA53C) begin
            n_fail++;
            $display("FAIL wf_a_lat1: got v=%b d=%h, want 1 a53c", o_rdv[0][0], o_rdata[0][0]);
        end
        step();
        n_tests++;
        if (o_rdv[1][0] !== 1'b1 || o_rdata[1][0] !== 16'hA53C) begin
            n_fail++;
            $display("FAIL wf_a_lat2: got v=%b d=%h, want 1 a53c", o_rdv[1][0], o_rdata[1][0]);
        end
    endtask

    task automatic test_collision();
        idle();
        a_cs = 1; a_wr = 1; a_address = 4'd3; a_be = 2'b01; a_wd = 16'h1111;
        b_cs = 1; b_wr = 1; b_address = 4'd3; b_be = 2'b11; b_wd = 16'h2222;
        step(); idle();
        n_tests++;
        if (o_coll[0] !== 1'b1 || o_coll[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL coll_pulse: got %b %b, want 1 1", o_coll[0], o_coll[1]);
        end
        a_cs = 1; a_rd = 1; a_address = 4'd3;
        step(); idle();
        n_tests++;
        if (o_coll[0] !== 1'b0 || o_coll[1] !== 1'b0 || o_rdata[0][0] !== 16'h2211 || o_rdv[0][0] !== 1'b1) begin
            n_fail++;
            $display("FAIL coll_after: got coll=%b%b d=%h v=%b, want 00 2211 1",
                     o_coll[0], o_coll[1], o_rdata[0][0], o_rdv[0][0]);
        end
        step();
        n_tests++;
        if (o_rdata[1][0] !== 16'h2211 || o_rdv[1][0] !== 1'b1) begin
            n_fail++;
            $display("FAIL coll_lat2: got d=%h v=%b, want 2211 1", o_rdata[1][0], o_rdv[1][0]);
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 300; n++) begin
            if (n < 296) begin
                a_cs = ($urandom_range(0, 3) != 0); a_rd = 1'($urandom); a_wr = 1'($urandom);
                b_cs = ($urandom_range(0, 3) != 0); b_rd = 1'($urandom); b_wr = 1'($urandom);
                a_address = (n % 2 == 0) ? 4'($urandom_range(0, 2)) : 4'($urandom);
                b_address = (n % 2 == 0) ? 4'($urandom_range(0, 2)) : 4'($urandom);
                a_be = 2'($urandom); b_be = 2'($urandom);
                a_wd = 16'($urandom); b_wd = 16'($urandom);
            end else idle();
            step();
            for (int l = 0; l < 2; l++) begin
                for (int p = 0; p < 2; p++) begin
                    n_tests++;
                    if (o_rdv[l][p] !== exp_rdv[l][p] || o_rdata[l][p] !== exp_rdata[l][p]) begin
                        n_fail++;
                        $display("FAIL b2b_read cyc%0d lat%0d p%0d: got v=%b d=%h, want v=%b d=%h",
                                 cyc, l + 1, p, o_rdv[l][p], o_rdata[l][p], exp_rdv[l][p], exp_rdata[l][p]);
                    end
                end
                n_tests++;
                if (o_coll[l] !== exp_coll) begin
                    n_fail++;
                    $display("FAIL b2b_coll cyc%0d lat%0d: got %b, want %b", cyc, l + 1, o_coll[l], exp_coll);
                end
`ifdef NPU_DPRAM_STATS_EN
                for (int i = 0; i < 5; i++) begin
                    n_tests++;
                    if (o_cnt[l][i] !== 32'(m_cnt[i])) begin
                        n_fail++;
                        $display("FAIL b2b_cnt%0d lat%0d: got %0d, want %0d", i, l + 1, o_cnt[l][i], m_cnt[i]);
                    end
                end
`endif
            end
        end
    endtask

    task automatic test_reset_during_clear();
        idle();
        for (int i = 0; i < 8; i++) begin
            a_cs = 1; a_wr = 1; a_be = 2'b11; a_address = 4'(i);     a_wd = 16'($urandom) | 16'h0101;
            b_cs = 1; b_wr = 1; b_be = 2'b11; b_address = 4'(i + 8); b_wd = 16'($urandom) | 16'h0101;
            step();
        end
        idle();
        reset = 1; step(); reset = 0;
        for (int i = 0; i < 9; i++) step();
        n_tests++;
        if (o_clr[0] !== 1'b1 || o_clr[1] !== 1'b1 || clr_ptr != 9) begin
            n_fail++;
            $display("FAIL rdc_mid: got clr=%b%b at model ptr %0d, want 11 at 9", o_clr[0], o_clr[1], clr_ptr);
        end
        reset = 1; step();
        for (int l = 0; l < 2; l++) begin
            n_tests++;
            if (o_rdata[l][0] !== 16'h0000 || o_rdata[l][1] !== 16'h0000 || o_coll[l] !== 1'b0) begin
                n_fail++;
                $display("FAIL rdc_reset lat%0d: got a=%h b=%h coll=%b, want 0000 0000 0",
                         l + 1, o_rdata[l][0], o_rdata[l][1], o_coll[l]);
            end
        end
        test_clear("rdc");
    endtask

`ifdef NPU_DPRAM_STATS_EN
    task automatic test_stats();
        int guard;
        idle();
        reset = 1; step(); reset = 0;
        guard = 0;
        while (o_clr[0] === 1'b1 && guard < 40) begin step(); guard++; end
        for (int l = 0; l < 2; l++) begin
            for (int i = 0; i < 5; i++) begin
                n_tests++;
                if (o_cnt[l][i] !== 32'd0) begin
                    n_fail++;
                    $display("FAIL stats_zero%0d lat%0d: got %0d, want 0", i, l + 1, o_cnt[l][i]);
                end
            end
        end
        for (int i = 1; i <= 3; i++) begin
            a_cs = 1; a_rd = 1; a_address = 4'(i); step();
        end
        idle();
        for (int i = 0; i < 2; i++) begin
            b_cs = 1; b_wr = 1; b_be = 2'b11; b_address = 4'(10 + i); b_wd = 16'h5555; step();
        end
        a_cs = 1; a_wr = 1; a_address = 4'd12; a_be = 2'b11; a_wd = 16'h0F0F;
        b_address = 4'd12; step();
        idle(); step();
        for (int l = 0; l < 2; l++) begin
            n_tests++;
            if (o_cnt[l][0] !== 32'd3 || o_cnt[l][1] !== 32'd1 || o_cnt[l][2] !== 32'd0 ||
                o_cnt[l][3] !== 32'd3 || o_cnt[l][4] !== 32'd1) begin
                n_fail++;
                $display("FAIL stats_vals lat%0d: got %0d %0d %0d %0d %0d, want 3 1 0 3 1", l + 1,
                         o_cnt[l][0], o_cnt[l][1], o_cnt[l][2], o_cnt[l][3], o_cnt[l][4]);
            end
        end
        reset = 1; step(); reset = 0;
        for (int l = 0; l < 2; l++) begin
            n_tests++;
            if ((o_cnt[l][0] | o_cnt[l][1] | o_cnt[l][2] | o_cnt[l][3] | o_cnt[l][4]) !== 32'd0) begin
                n_fail++;
                $display("FAIL stats_reset lat%0d: got %0d %0d %0d %0d %0d, want all 0", l + 1,
                         o_cnt[l][0], o_cnt[l][1], o_cnt[l][2], o_cnt[l][3], o_cnt[l][4]);
            end
        end
    endtask
`endif

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0; clr_ptr = 0;
        for (int i = 0; i < 5; i++) m_cnt[i] = 0;
        reset = 1;
        idle();
        test_reset();
        test_clear("clear");
        test_byte_enable();
        test_write_first();
        test_collision();
        test_back_to_back();
        test_reset_during_clear();
`ifdef NPU_DPRAM_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
